// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with grant hold.
//
// Purpose:
//   Grants one shared resource to one of four requesters. A rotating
//   priority search picks the first active request at or after the index
//   following the previous winner (wrapping 3->0). A grant is held until
//   the holder pulses done. Exactly one idle cycle separates grants.
//
// Parameters:
//   NREQ      number of requesters; fixed at 4, present for checking only
//   MAX_HOLD  maximum grant length in cycles (2..255); used only when the
//             ARB_TIMEOUT_EN macro is defined
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Defined   -> an 8-bit hold counter force-releases a grant after
//                MAX_HOLD cycles and pulses timeout for one cycle.
//   Undefined -> grants are held until done; timeout is tied 0.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   4  level-sensitive request vector, bit i = requester i
//   done      in   1  single-cycle release pulse from the current holder
//   grant     out  4  registered one-hot grant, zero when idle
//   grant_id  out  2  index of the current holder; holds last winner idle
//   busy      out  1  high while a grant is active (mirrors FSM state)
//   timeout   out  1  single-cycle pulse after a forced release
//
// Handshake: req is a level, sampled only in IDLE with no latching; a
// winner owns the resource from the edge grant rises until the edge at
// which done=1 is sampled (or the hold limit expires). done outside a
// grant is ignored.

module rr_arbiter4 #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  if (NREQ != 4) begin : g_bad_nreq
    $error("rr_arbiter4: NREQ must be 4");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter4: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q;
  logic [3:0] grant_q;
  logic [1:0] grant_id_q;
  logic [1:0] last_q;

  logic       win_vld_d;
  logic [1:0] win_idx_d;
  logic [3:0] grant_d;
  logic [1:0] cand;
  logic       hold_expired;
  logic       release_ev;

  // Rotating-priority search: candidates last+1, last+2, last+3, last.
  // The 2-bit add wraps naturally, so k=4 lands back on last itself.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = last_q;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_vld_d && req[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand;
      end
    end
    grant_d = 4'b0001 << win_idx_d;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q;
  logic       timeout_q;
  // Counter is 0 in the first grant cycle, so reaching MAX_HOLD-1 means the
  // grant has been visible for MAX_HOLD cycles by the releasing edge.
  assign hold_expired = (hold_cnt_q == HoldLast);
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign release_ev = done | hold_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= 2'd3;  // requester 0 wins first after reset
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q    <= S_GRANT;
            grant_q    <= grant_d;
            grant_id_q <= win_idx_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (release_ev) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= grant_id_q;  // pointer moves only on release
`ifdef ARB_TIMEOUT_EN
            // done in the same cycle wins: a normal release, no pulse.
            timeout_q <= ~done;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter4 #(.NREQ(4), .MAX_HOLD(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

`ifdef ARB_TIMEOUT_EN
  logic [3:0] req_t;
  logic       done_t;
  logic [3:0] grant_t;
  logic [1:0] grant_id_t;
  logic       busy_t;
  logic       timeout_t;

  rr_arbiter4 #(.NREQ(4), .MAX_HOLD(4)) u_dut_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_t),
    .done     (done_t),
    .grant    (grant_t),
    .grant_id (grant_id_t),
    .busy     (busy_t),
    .timeout  (timeout_t)
  );
`endif

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the current grant one more cycle, then pulse done and check idle.
  task automatic release_grant(input logic [3:0] held);
    tick();
    chk("held_before_done", 8'(grant), 8'(held));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_grant", 8'(grant), 8'h0);
    chk("idle_busy", 8'(busy), 8'h0);
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] rot_seq [4];

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    req_t  = 4'b0000;
    done_t = 1'b0;
`endif
    rot_seq[0] = 4'b0010;
    rot_seq[1] = 4'b0100;
    rot_seq[2] = 4'b1000;
    rot_seq[3] = 4'b0001;

    tick();
    tick();
    chk("rst_grant", 8'(grant), 8'h0);
    chk("rst_grant_id", 8'(grant_id), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_timeout", 8'(timeout), 8'h0);

    // Reset mid-grant: get grant=0010, then reset between edges.
    rst_n = 1'b1;
    req   = 4'b0010;
    tick();
    chk("pre_rst_grant", 8'(grant), 8'h2);
    chk("pre_rst_id", 8'(grant_id), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 8'(grant), 8'h0);
    chk("async_rst_busy", 8'(busy), 8'h0);
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    chk("post_rst_grant", 8'(grant), 8'h1);
    chk("post_rst_id", 8'(grant_id), 8'h0);
    chk("post_rst_busy", 8'(busy), 8'h1);

    // Rotation with all requesters active.
    for (int i = 0; i < 4; i++) begin
      release_grant((i == 0) ? 4'b0001 : rot_seq[i-1]);
      tick();
      chk("rot_grant", 8'(grant), 8'(rot_seq[i]));
      chk("rot_id", 8'(grant_id), 8'((i + 1) % 4));
    end

    // Skip idle requesters: last becomes 0, req=1001 -> 3, then 0.
    release_grant(4'b0001);
    req = 4'b1001;
    tick();
    chk("skip_grant3", 8'(grant), 8'h8);
    chk("skip_id3", 8'(grant_id), 8'h3);
    release_grant(4'b1000);
    tick();
    chk("skip_grant0", 8'(grant), 8'h1);

    // Hold and drop: grant 0100, req withdrawn, grant must stay.
    req = 4'b0100;
    release_grant(4'b0001);
    tick();
    chk("hold_grant", 8'(grant), 8'h4);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_drop_grant", 8'(grant), 8'h4);
      chk("hold_drop_busy", 8'(busy), 8'h1);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("hold_rel_grant", 8'(grant), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stay_idle_grant", 8'(grant), 8'h0);
      chk("stay_idle_busy", 8'(busy), 8'h0);
    end
    chk("idle_keeps_id", 8'(grant_id), 8'h2);

    // Single requester: granted every second cycle.
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_grant", 8'(grant), 8'h2);
      chk("single_id", 8'(grant_id), 8'h1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("single_gap", 8'(grant), 8'h0);
    end

    // Long hold on the MAX_HOLD=16 instance with no done.
    req = 4'b0001;
    tick();
    chk("long_grant_start", 8'(grant), 8'h1);
`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("long_grant_held", 8'(grant), 8'h1);
      chk("long_no_timeout", 8'(timeout), 8'h0);
    end
`endif
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    chk("long_rel", 8'(grant), 8'h0);

`ifdef ARB_TIMEOUT_EN
    // Timeout instance, MAX_HOLD=4: grant visible exactly 4 samples.
    req_t = 4'b0001;
    tick();
    chk("to_grant_c0", 8'(grant_t), 8'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_grant_held", 8'(grant_t), 8'h1);
      chk("to_no_pulse", 8'(timeout_t), 8'h0);
    end
    tick();
    chk("to_released", 8'(grant_t), 8'h0);
    chk("to_pulse", 8'(timeout_t), 8'h1);
    chk("to_busy", 8'(busy_t), 8'h0);
    tick();
    chk("to_regrant", 8'(grant_t), 8'h1);
    chk("to_pulse_end", 8'(timeout_t), 8'h0);
    req_t  = 4'b0000;
    done_t = 1'b1;
    tick();
    done_t = 1'b0;
    chk("to_done_rel", 8'(grant_t), 8'h0);
    chk("to_done_no_pulse", 8'(timeout_t), 8'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter granting exclusive use of one shared resource (e.g. a downstream datapath or bus slot).
- Selection uses a rotating-priority search: the first active request at or after the index following the last winner, wrapping 3→0.
- Each grant is held until the winner pulses done. The block provides the sequencing and fairness layer around the team's combinational priority-encode logic.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 for this block, present for documentation and checking only.
- MAX_HOLD, 16, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i high = requester i wants the resource; level-sensitive
- done  input  1  single-cycle release pulse from the current grant holder; ignored when no grant is active
- grant  output  4  one-hot grant, registered; all-zero when idle
- grant_id  output  2  binary index of the current holder, registered; holds the last winner when idle
- busy  output  1  high while any grant is active
- timeout  output  1  single-cycle pulse on a forced release; present only with ARB_TIMEOUT_EN, otherwise tied 0

Behaviour:
- Reset (async, rst_n=0):
  - grant=4'b0000, grant_id=2'b00, busy=0, timeout=0.
  - Internal last pointer = 2'd3, so requester 0 has highest priority after reset.
  - Hold counter = 0, state = IDLE.
- Reset may assert at any time, including mid-grant. Outputs clear immediately, without waiting for a clock edge. The first grant after reset release follows the IDLE rules.
- FSM states:
  - IDLE: no grant. On a rising edge with req!=0:
    - Winner = first set bit scanning last+1, last+2, last+3, last (mod 4).
    - Register grant/grant_id/busy=1 and go to GRANT.
    - With req==0, stay in IDLE.
  - GRANT: grant held stable regardless of req changes. On a rising edge with done=1:
    - Clear grant, busy=0, last<=grant_id, go to IDLE.
- Latency:
  - grant rises on the first rising edge at which req is seen nonzero in IDLE (1 cycle from req).
  - grant falls on the edge at which done=1 is sampled.
- Back-to-back grants: one mandatory idle cycle (grant=0) between consecutive grants. The next winner is chosen from req sampled in that IDLE cycle.
- Requester dropping req while granted does not release the grant; only done (or timeout) releases.
- A request withdrawn before being sampled in IDLE is simply not considered; there is no request latching.
- Fairness: with all four req held high and every holder pulsing done, the grant order is 0,1,2,3,0,... No requester waits more than 3 other grants.
- The last pointer updates only on release, never in IDLE.
- grant is always one-hot or zero. grant_id is valid only when busy=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 without done, the next edge force-releases exactly like done: pointer update, go IDLE, timeout=1 for that one cycle.
  - done and the timeout condition in the same cycle count as a normal release; timeout stays 0.
- Undefined: no counter; a grant is held indefinitely until done; timeout is constant 0.

Test Plan:
- Reset mid-grant: grant=0010 active, assert rst_n=0 between edges -> grant=0000, busy=0 immediately. Release rst_n, req=1111 -> first grant=0001, grant_id=0.
- Rotation: req=1111 held, done pulsed 2 cycles after each grant -> grant sequence 0001,0010,0100,1000,0001, each separated by one grant=0000 cycle.
- Skip idle requesters: last=0, req=1001 -> grant=1000. After done -> grant=0001.
- Hold and drop: grant=0100, req drops to 0000 for 5 cycles without done -> grant stays 0100, busy=1. Done -> grant=0000, and with req=0 the block stays IDLE.
- Single requester: req=0010 only, repeated done -> grant=0010 every second cycle. grant_id=1 throughout each grant.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=0001, no done -> grant high exactly 4 cycles, timeout pulses 1 cycle, next grant follows IDLE rules. Without the macro -> grant stays high for 20+ cycles and timeout stays 0.
